multicycle_alu: RTL and testbench

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu.sv | 232 +++++++++++++++++++++++
 tb/tb_multicycle_alu.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative shift-add MUL
// and restoring DIVU, behind a valid/ready handshake on both sides.
module multicycle_alu #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned OUT_W = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] ina,
   input  logic [WIDTH-1:0] inb,
   input  logic [WIDTH-1:0] imm,
   input  logic             alusrc,
   input  logic             addi,
   input  logic [2:0]       aluctr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_w,
   output logic [OUT_W-1:0] out_n,
   output logic             zero,
   output logic             carry,
   output logic             less,
   output logic             busy
);

   localparam int unsigned SH_W  = $clog2(WIDTH);
   localparam int unsigned CNT_W = SH_W;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_OR  = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SLL = 3'd5;
   localparam logic [2:0] OP_MUL = 3'd6;
   localparam logic [2:0] OP_DIV = 3'd7;

   if (WIDTH < 8 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
      $error("multicycle_alu: WIDTH must be a power of two in 8..64");
   end
   if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
      $error("multicycle_alu: OUT_W must be in 1..WIDTH");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e             state_q;
   logic [2:0]         op_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   opnd_q;   // multiplicand (MUL) or divisor (DIVU)
   logic [WIDTH-1:0]   hi_q;     // product high half or partial remainder
   logic [WIDTH-1:0]   lo_q;     // multiplier/product low half or dividend/quotient
   logic               in_ready_q;
   logic               out_valid_q;
   logic               busy_q;
   logic [WIDTH-1:0]   out_w_q;
   logic               zero_q;
   logic               carry_q;
   logic               less_q;

   logic [WIDTH-1:0]   b_sel;
   logic [WIDTH:0]     add_s;
   logic [WIDTH:0]     sub_s;
   logic               add_ovf;
   logic               sub_ovf;
   logic [WIDTH-1:0]   imm_res;
   logic               imm_carry;
   logic               imm_less;

   logic [WIDTH-1:0]   mul_addend;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH-1:0]   mul_hi_d;
   logic [WIDTH-1:0]   mul_lo_d;
   logic [WIDTH:0]     div_sh;
   logic [WIDTH:0]     div_diff;
   logic               div_ok;
   logic [WIDTH-1:0]   div_hi_d;
   logic [WIDTH-1:0]   div_lo_d;
   logic [WIDTH-1:0]   ex_res;
   logic               ex_carry;
   logic               ex_last;

   // Single-cycle datapath, evaluated on the request operands at accept time
   always_comb begin
      b_sel     = alusrc ? imm : inb;
      add_s     = {1'b0, ina} + {1'b0, b_sel};
      sub_s     = {1'b0, ina} - {1'b0, b_sel};
      add_ovf   = (ina[WIDTH-1] == b_sel[WIDTH-1]) && (add_s[WIDTH-1] != ina[WIDTH-1]);
      sub_ovf   = (ina[WIDTH-1] != b_sel[WIDTH-1]) && (sub_s[WIDTH-1] != ina[WIDTH-1]);
      imm_res   = '0;
      imm_carry = 1'b0;
      imm_less  = 1'b0;
      case (aluctr)
         OP_ADD: begin
            if (addi) begin
               imm_carry = add_ovf;
               imm_res   = add_ovf ? '0 : add_s[WIDTH-1:0];
            end else begin
               imm_carry = add_s[WIDTH];
               imm_res   = add_s[WIDTH-1:0];
            end
         end
         OP_SUB: begin
            imm_res   = sub_s[WIDTH-1:0];
            imm_carry = sub_s[WIDTH];
            imm_less  = sub_s[WIDTH-1] ^ sub_ovf;
         end
         OP_OR:   imm_res = ina | b_sel;
         OP_AND:  imm_res = ina & b_sel;
         OP_XOR:  imm_res = ina ^ b_sel;
         OP_SLL:  imm_res = ina << b_sel[SH_W-1:0];
         default: imm_res = '0;
      endcase
   end

   // One iteration step of shift-add MUL and restoring DIVU
   always_comb begin
      mul_addend = lo_q[0] ? opnd_q : {WIDTH{1'b0}};
      mul_sum    = {1'b0, hi_q} + {1'b0, mul_addend};
      mul_hi_d   = mul_sum[WIDTH:1];
      mul_lo_d   = {mul_sum[0], lo_q[WIDTH-1:1]};

      div_sh     = {hi_q, lo_q[WIDTH-1]};
      div_diff   = div_sh - {1'b0, opnd_q};
      div_ok     = ~div_diff[WIDTH];
      div_hi_d   = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
      div_lo_d   = {lo_q[WIDTH-2:0], div_ok};

      ex_res     = (op_q == OP_DIV) ? div_lo_d : mul_lo_d;
      ex_carry   = (op_q == OP_DIV) ? (opnd_q == '0) : (mul_hi_d != '0);
      ex_last    = (cnt_q == CNT_W'(WIDTH - 1));
   end

   // Control FSM with registered handshake, status and result outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= '0;
         cnt_q       <= '0;
         opnd_q      <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         out_w_q     <= '0;
         zero_q      <= 1'b0;
         carry_q     <= 1'b0;
         less_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  op_q  <= aluctr;
                  cnt_q <= '0;
                  hi_q  <= '0;
                  if (aluctr == OP_MUL) begin
                     opnd_q     <= ina;
                     lo_q       <= b_sel;
                     state_q    <= EXEC;
                     busy_q     <= 1'b1;
                     in_ready_q <= 1'b0;
                  end else if (aluctr == OP_DIV) begin
                     opnd_q     <= b_sel;
                     lo_q       <= ina;
                     state_q    <= EXEC;
                     busy_q     <= 1'b1;
                     in_ready_q <= 1'b0;
                  end else begin
                     opnd_q      <= b_sel;
                     lo_q        <= ina;
                     out_w_q     <= imm_res;
                     zero_q      <= (imm_res == '0);
                     carry_q     <= imm_carry;
                     less_q      <= imm_less;
                     state_q     <= DONE;
                     out_valid_q <= 1'b1;
                     in_ready_q  <= 1'b0;
                  end
               end
            end
            EXEC: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (op_q == OP_DIV) begin
                  hi_q <= div_hi_d;
                  lo_q <= div_lo_d;
               end else begin
                  hi_q <= mul_hi_d;
                  lo_q <= mul_lo_d;
               end
               if (ex_last) begin
                  out_w_q     <= ex_res;
                  zero_q      <= (ex_res == '0);
                  carry_q     <= ex_carry;
                  less_q      <= 1'b0;
                  state_q     <= DONE;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign out_w     = out_w_q;
   assign out_n     = out_w_q[OUT_W-1:0];
   assign zero      = zero_q;
   assign carry     = carry_q;
   assign less      = less_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: a 32/10 instance and an 8/4 instance.
module tb_multicycle_alu;

   logic clk;
   logic rst_n;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_in_valid, a_in_ready, a_alusrc, a_addi, a_out_valid, a_out_ready;
   logic [31:0] a_ina, a_inb, a_imm, a_out_w;
   logic [2:0]  a_aluctr;
   logic [9:0]  a_out_n;
   logic        a_zero, a_carry, a_less, a_busy;

   logic        b_in_valid, b_in_ready, b_alusrc, b_addi, b_out_valid, b_out_ready;
   logic [7:0]  b_ina, b_inb, b_imm, b_out_w;
   logic [2:0]  b_aluctr;
   logic [3:0]  b_out_n;
   logic        b_zero, b_carry, b_less, b_busy;

   int checks   = 0;
   int failures = 0;

   multicycle_alu #(.WIDTH(32), .OUT_W(10)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .ina(a_ina), .inb(a_inb), .imm(a_imm), .alusrc(a_alusrc), .addi(a_addi),
      .aluctr(a_aluctr), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_w(a_out_w), .out_n(a_out_n), .zero(a_zero), .carry(a_carry),
      .less(a_less), .busy(a_busy)
   );

   multicycle_alu #(.WIDTH(8), .OUT_W(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .ina(b_ina), .inb(b_inb), .imm(b_imm), .alusrc(b_alusrc), .addi(b_addi),
      .aluctr(b_aluctr), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_w(b_out_w), .out_n(b_out_n), .zero(b_zero), .carry(b_carry),
      .less(b_less), .busy(b_busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Present one request to instance A for one cycle, then scramble its inputs
   task automatic issue_a(input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                          input logic src, input logic ad, input logic [2:0] op);
      a_ina = a; a_inb = b; a_imm = im; a_alusrc = src; a_addi = ad; a_aluctr = op;
      a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      a_ina = 32'hDEADBEEF; a_inb = 32'h13572468; a_imm = 32'hCAFEF00D;
      a_alusrc = ~src; a_addi = ~ad; a_aluctr = ~op;
   endtask

   task automatic wait_a(output int lat, output int bcnt);
      lat  = 1;
      bcnt = 0;
      while (!a_out_valid && lat < 200) begin
         if (a_busy) bcnt++;
         tick();
         lat++;
      end
   endtask

   // Check a presented result on A, retire it, and check return to IDLE
   task automatic res_a(input string tag, input logic [31:0] w, input logic c,
                        input logic z, input logic l);
      chk({tag, "/valid"}, 64'(a_out_valid), 64'd1);
      chk({tag, "/out_w"}, 64'(a_out_w), 64'(w));
      chk({tag, "/out_n"}, 64'(a_out_n), 64'(w[9:0]));
      chk({tag, "/carry"}, 64'(a_carry), 64'(c));
      chk({tag, "/zero"},  64'(a_zero),  64'(z));
      chk({tag, "/less"},  64'(a_less),  64'(l));
      tick();
      chk({tag, "/ready"}, 64'(a_in_ready), 64'd1);
   endtask

   int lat, bcnt, saw;

   initial begin
      rst_n = 1'b0;
      a_in_valid = 1'b1; a_out_ready = 1'b1; a_ina = 32'd1; a_inb = 32'd1; a_imm = '0;
      a_alusrc = 1'b0; a_addi = 1'b0; a_aluctr = 3'd0;
      b_in_valid = 1'b1; b_out_ready = 1'b1; b_ina = 8'd1; b_inb = 8'd1; b_imm = '0;
      b_alusrc = 1'b0; b_addi = 1'b0; b_aluctr = 3'd0;
      tick();
      tick();
      chk("rst/in_ready",  64'(a_in_ready), 64'd1);
      chk("rst/out_valid", 64'(a_out_valid), 64'd0);
      chk("rst/busy",      64'(a_busy), 64'd0);
      chk("rst/out_w",     64'(a_out_w), 64'd0);
      chk("rst/flags",     64'({a_zero, a_carry, a_less}), 64'd0);
      chk("rst_b/in_ready", 64'(b_in_ready), 64'd1);
      a_in_valid = 1'b0; b_in_valid = 1'b0;
      rst_n = 1'b1;
      tick();
      chk("rst/no_accept", 64'({a_in_ready, a_out_valid}), 64'b10);

      // ADD trapping overflow
      issue_a(32'h7FFFFFFF, 32'd1, 32'd0, 1'b0, 1'b1, 3'd0);
      chk("addi/in_ready", 64'(a_in_ready), 64'd0);
      wait_a(lat, bcnt);
      chk("addi/lat", 64'(lat), 64'd1);
      res_a("addi", 32'd0, 1'b1, 1'b1, 1'b0);

      issue_a(32'hFFFFFFFF, 32'd2, 32'd0, 1'b0, 1'b0, 3'd0);
      wait_a(lat, bcnt);
      res_a("add_carry", 32'd1, 1'b1, 1'b0, 1'b0);

      issue_a(32'h80000000, 32'd1, 32'd0, 1'b0, 1'b0, 3'd1);
      wait_a(lat, bcnt);
      res_a("sub_ovf", 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1);

      issue_a(32'd5, 32'd5, 32'd0, 1'b0, 1'b0, 3'd1);
      wait_a(lat, bcnt);
      res_a("sub_eq", 32'd0, 1'b0, 1'b1, 1'b0);

      issue_a(32'd1, 32'd0, 32'd2, 1'b1, 1'b0, 3'd1);
      wait_a(lat, bcnt);
      res_a("sub_imm", 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1);

      issue_a(32'h0000F0F0, 32'h0000FF00, 32'd0, 1'b0, 1'b0, 3'd4);
      wait_a(lat, bcnt);
      res_a("xor", 32'h00000FF0, 1'b0, 1'b0, 1'b0);

      issue_a(32'hFF00FF00, 32'h0F0F0F0F, 32'd0, 1'b0, 1'b0, 3'd3);
      wait_a(lat, bcnt);
      res_a("and", 32'h0F000F00, 1'b0, 1'b0, 1'b0);

      issue_a(32'd1, 32'h00000025, 32'd0, 1'b0, 1'b0, 3'd5);
      wait_a(lat, bcnt);
      res_a("sll", 32'h00000020, 1'b0, 1'b0, 1'b0);

      // OR with consumer stall; in_valid pulses must be ignored
      a_out_ready = 1'b0;
      issue_a(32'h00000300, 32'h000000FF, 32'd0, 1'b0, 1'b0, 3'd2);
      for (int i = 0; i < 5; i++) begin
         chk("stall/out_w",  64'(a_out_w), 64'h3FF);
         chk("stall/state",  64'({a_out_valid, a_in_ready, a_busy}), 64'b100);
         chk("stall/flags",  64'({a_out_n, a_zero, a_carry, a_less}), 64'({10'h3FF, 3'b000}));
         a_in_valid = (i % 2 == 0);
         a_ina = 32'd7; a_inb = 32'd9; a_aluctr = 3'd0;
         tick();
      end
      a_in_valid = 1'b0;
      a_out_ready = 1'b1;
      res_a("stall", 32'h3FF, 1'b0, 1'b0, 1'b0);
      tick();
      chk("stall/no_queue", 64'(a_out_valid), 64'd0);

      // MUL overflow: latency and busy window
      issue_a(32'h00010000, 32'h5, 32'h00010000, 1'b1, 1'b0, 3'd6);
      wait_a(lat, bcnt);
      chk("mul/lat",  64'(lat), 64'd33);
      chk("mul/busy", 64'(bcnt), 64'd32);
      res_a("mul", 32'd0, 1'b1, 1'b1, 1'b0);

      issue_a(32'h00012345, 32'h10, 32'd0, 1'b0, 1'b0, 3'd6);
      wait_a(lat, bcnt);
      res_a("mul_small", 32'h00123450, 1'b0, 1'b0, 1'b0);

      issue_a(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 3'd6);
      wait_a(lat, bcnt);
      res_a("mul_max", 32'h00000001, 1'b1, 1'b0, 1'b0);

      issue_a(32'd100, 32'd7, 32'd0, 1'b0, 1'b0, 3'd7);
      wait_a(lat, bcnt);
      chk("div/lat", 64'(lat), 64'd33);
      res_a("div", 32'd14, 1'b0, 1'b0, 1'b0);

      issue_a(32'hFFFFFFFF, 32'h10, 32'd0, 1'b0, 1'b0, 3'd7);
      wait_a(lat, bcnt);
      res_a("div_big", 32'h0FFFFFFF, 1'b0, 1'b0, 1'b0);

      issue_a(32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 3'd7);
      wait_a(lat, bcnt);
      chk("div0/lat", 64'(lat), 64'd33);
      res_a("div0", 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);

      // Reset in cycle 10 of EXEC aborts the divide
      issue_a(32'd1000, 32'd3, 32'd0, 1'b0, 1'b0, 3'd7);
      for (int i = 1; i < 10; i++) tick();
      chk("abort/busy_pre", 64'(a_busy), 64'd1);
      rst_n = 1'b0;
      tick();
      chk("abort/state", 64'({a_in_ready, a_out_valid, a_busy}), 64'b100);
      chk("abort/out_w", 64'(a_out_w), 64'd0);
      chk("abort/flags", 64'({a_out_n, a_zero, a_carry, a_less}), 64'd0);
      rst_n = 1'b1;
      saw = 0;
      for (int i = 0; i < 40; i++) begin
         if (a_out_valid || a_busy) saw++;
         tick();
      end
      chk("abort/no_result", 64'(saw), 64'd0);

      // Reset while a result waits in DONE
      a_out_ready = 1'b0;
      issue_a(32'd2, 32'd3, 32'd0, 1'b0, 1'b0, 3'd0);
      chk("abort_done/valid", 64'(a_out_valid), 64'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      a_out_ready = 1'b1;
      tick();
      chk("abort_done/state", 64'({a_in_ready, a_out_valid, a_out_w}), 64'({1'b1, 1'b0, 32'd0}));

      // Narrow instance: WIDTH=8, OUT_W=4
      b_ina = 8'd15; b_inb = 8'd17; b_alusrc = 1'b0; b_aluctr = 3'd6; b_in_valid = 1'b1;
      tick();
      b_in_valid = 1'b0; b_ina = 8'hAA; b_inb = 8'h55;
      lat = 1;
      while (!b_out_valid && lat < 100) begin tick(); lat++; end
      chk("b_mul/lat",   64'(lat), 64'd9);
      chk("b_mul/out_w", 64'(b_out_w), 64'hFF);
      chk("b_mul/out_n", 64'(b_out_n), 64'hF);
      chk("b_mul/flags", 64'({b_carry, b_zero, b_less}), 64'd0);
      tick();
      chk("b_mul/ready", 64'(b_in_ready), 64'd1);

      b_ina = 8'd200; b_inb = 8'd7; b_aluctr = 3'd7; b_in_valid = 1'b1;
      tick();
      b_in_valid = 1'b0; b_inb = 8'd0;
      lat = 1;
      while (!b_out_valid && lat < 100) begin tick(); lat++; end
      chk("b_div/lat",   64'(lat), 64'd9);
      chk("b_div/out_w", 64'(b_out_w), 64'h1C);
      chk("b_div/out_n", 64'(b_out_n), 64'hC);
      chk("b_div/carry", 64'(b_carry), 64'd0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
